// File: rtl/rv_lsu.sv
// rv_lsu: RV32I memory-stage load/store unit driving a req/gnt/rvalid data bus.
// Optional macro RV_LSU_ALIGN_CHECK_EN: trap misaligned accesses instead of force-aligning them.
module rv_lsu #(
    parameter int XLEN          = 32,
    parameter int DMEM_ADDR_BIT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ex_valid_i,
    input  logic                     ex_we_i,
    input  logic [2:0]               ex_func3_i,
    input  logic [XLEN-1:0]          ex_addr_i,
    input  logic [XLEN-1:0]          ex_wdata_i,
    output logic                     lsu_stall_o,
    output logic                     lsu_rvalid_o,
    output logic [XLEN-1:0]          lsu_rdata_o,
    output logic                     lsu_err_o,
    output logic                     dmem_req_o,
    output logic                     dmem_we_o,
    output logic [3:0]               dmem_be_o,
    output logic [DMEM_ADDR_BIT-3:0] dmem_addr_o,
    output logic [31:0]              dmem_wdata_o,
    input  logic                     dmem_gnt_i,
    input  logic                     dmem_rvalid_i,
    input  logic [31:0]              dmem_rdata_i
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
    typedef enum logic [2:0] {
        F3_BYTE  = 3'd0,
        F3_HALF  = 3'd1,
        F3_WORD  = 3'd2,
        F3_BYTEU = 3'd4,
        F3_HALFU = 3'd5
    } func3_dmem_e;

    state_e                   state_reg, state_next;
    logic                     we_reg;
    logic [2:0]               func3_reg;
    logic [1:0]               off_reg;
    logic [DMEM_ADDR_BIT-3:0] addr_reg;
    logic [3:0]               be_reg;
    logic [31:0]              wdata_reg;
    logic                     rvalid_reg;
    logic [XLEN-1:0]          rdata_reg;

    logic                     is_byte, is_half, misaligned;
    logic [1:0]               off_eff;
    logic [3:0]               be_next;
    logic [31:0]              wdata_next;
    logic                     accept, done, load_done;
    logic [31:0]              shifted;
    logic [XLEN-1:0]          load_ext;
    logic                     unused_addr;

    assign unused_addr = ^ex_addr_i[XLEN-1:DMEM_ADDR_BIT];

    // func3 values 3, 6 and 7 fall through to word handling
    assign is_byte = (ex_func3_i == F3_BYTE) || (ex_func3_i == F3_BYTEU);
    assign is_half = (ex_func3_i == F3_HALF) || (ex_func3_i == F3_HALFU);

`ifdef RV_LSU_ALIGN_CHECK_EN
    assign misaligned = is_half ? ex_addr_i[0] : (!is_byte && (ex_addr_i[1:0] != 2'b00));
    assign off_eff    = ex_addr_i[1:0];
`else
    // Without the check, drop the low offset bits so the access is naturally aligned
    assign misaligned = 1'b0;
    assign off_eff    = is_byte ? ex_addr_i[1:0] : (is_half ? {ex_addr_i[1], 1'b0} : 2'b00);
`endif

    always_comb begin
        be_next    = 4'hF;
        wdata_next = ex_wdata_i;
        if (is_byte) begin
            be_next    = 4'b0001 << off_eff;
            wdata_next = {4{ex_wdata_i[7:0]}};
        end else if (is_half) begin
            be_next    = 4'b0011 << off_eff;
            wdata_next = {2{ex_wdata_i[15:0]}};
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        done       = 1'b0;
        load_done  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (ex_valid_i) begin
                    if (misaligned) begin
                        done = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = REQ;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    if (we_reg) begin
                        done       = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = RESP;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid_i) begin
                    done       = 1'b1;
                    load_done  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Bus-side request fields stay frozen from acceptance until the grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_reg    <= 1'b0;
            func3_reg <= 3'd0;
            off_reg   <= 2'd0;
            addr_reg  <= '0;
            be_reg    <= 4'd0;
            wdata_reg <= 32'd0;
        end else if (accept) begin
            we_reg    <= ex_we_i;
            func3_reg <= ex_func3_i;
            off_reg   <= off_eff;
            addr_reg  <= ex_addr_i[DMEM_ADDR_BIT-1:2];
            be_reg    <= be_next;
            wdata_reg <= wdata_next;
        end
    end

    always_comb begin
        shifted = dmem_rdata_i >> {off_reg, 3'b000};
        case (func3_reg)
            F3_BYTE:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            F3_BYTEU: load_ext = {24'd0, shifted[7:0]};
            F3_HALF:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            F3_HALFU: load_ext = {16'd0, shifted[15:0]};
            default:  load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= load_done;
            if (load_done) begin
                rdata_reg <= load_ext;
            end
        end
    end

`ifdef RV_LSU_ALIGN_CHECK_EN
    logic err_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else begin
            err_reg <= (state_reg == IDLE) && ex_valid_i && misaligned;
        end
    end
    assign lsu_err_o = err_reg;
`else
    assign lsu_err_o = 1'b0;
`endif

    assign lsu_stall_o  = ex_valid_i & ~done;
    assign lsu_rvalid_o = rvalid_reg;
    assign lsu_rdata_o  = rdata_reg;
    assign dmem_req_o   = (state_reg == REQ);
    assign dmem_we_o    = we_reg;
    assign dmem_be_o    = be_reg;
    assign dmem_addr_o  = addr_reg;
    assign dmem_wdata_o = wdata_reg;

endmodule

// File: tb/tb_rv_lsu.sv
// Scoreboard bench for rv_lsu: directed ops queue expected bus/load results, a monitor checks them.
module tb_rv_lsu;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ex_valid, ex_we;
    logic [2:0]  ex_func3;
    logic [31:0] ex_addr, ex_wdata;
    logic        lsu_stall, lsu_rvalid, lsu_err;
    logic [31:0] lsu_rdata;
    logic        dmem_req, dmem_we;
    logic [3:0]  dmem_be;
    logic [13:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;

    rv_lsu #(.XLEN(32), .DMEM_ADDR_BIT(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid_i   (ex_valid),
        .ex_we_i      (ex_we),
        .ex_func3_i   (ex_func3),
        .ex_addr_i    (ex_addr),
        .ex_wdata_i   (ex_wdata),
        .lsu_stall_o  (lsu_stall),
        .lsu_rvalid_o (lsu_rvalid),
        .lsu_rdata_o  (lsu_rdata),
        .lsu_err_o    (lsu_err),
        .dmem_req_o   (dmem_req),
        .dmem_we_o    (dmem_we),
        .dmem_be_o    (dmem_be),
        .dmem_addr_o  (dmem_addr),
        .dmem_wdata_o (dmem_wdata),
        .dmem_gnt_i   (dmem_gnt),
        .dmem_rvalid_i(dmem_rvalid),
        .dmem_rdata_i (dmem_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_t;

    bus_t        bus_q[$];
    logic [31:0] rd_q[$];

    int pass_cnt = 0, total_cnt = 0;
    int cyc = 0, rv_pulses = 0, err_pulses = 0;
    int last_store_gnt = 0, req_rise = 0;
    logic req_prev = 1'b0;

    int          gnt_wait = 0, rv_wait = 0, req_cnt = 0, rv_cnt = 0;
    logic        spur = 1'b0, pend = 1'b0;
    logic [31:0] rd_word = 32'd0;

`ifdef RV_LSU_ALIGN_CHECK_EN
    localparam int EXP_ERRS = 2;
`else
    localparam int EXP_ERRS = 0;
`endif

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: grant after gnt_wait request cycles, read data rv_wait cycles after the grant
    initial begin
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        forever begin
            @(posedge clk); #1;
            dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
            if (!rst_n) begin
                req_cnt = 0;
            end else begin
                if (pend) begin
                    if (rv_cnt == rv_wait) begin
                        dmem_rvalid = 1'b1; dmem_rdata = rd_word; pend = 1'b0;
                    end else rv_cnt++;
                end
                if (dmem_req) begin
                    if (spur) begin dmem_rvalid = 1'b1; dmem_rdata = 32'hDEADBEEF; end
                    if (req_cnt == gnt_wait) begin
                        dmem_gnt = 1'b1; req_cnt = 0;
                        if (!dmem_we) begin pend = 1'b1; rv_cnt = 0; end
                    end else req_cnt++;
                end
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a granted request or a load result
    initial begin
        bus_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                req_prev = 1'b0;
            end else begin
                if (dmem_req && dmem_gnt) begin
                    if (bus_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_bus: got access addr 0x%04h be 0x%01h, required no access", dmem_addr, dmem_be);
                    end else begin
                        e = bus_q.pop_front();
                        chk("bus_we", 32'(dmem_we), 32'(e.we));
                        chk("bus_be", 32'(dmem_be), 32'(e.be));
                        chk("bus_addr", 32'(dmem_addr), e.addr);
                        if (e.we) chk("bus_wdata", dmem_wdata, e.wdata);
                        if (dmem_we) last_store_gnt = cyc;
                    end
                end
                if (dmem_req && !req_prev) req_rise = cyc;
                req_prev = dmem_req;
                if (lsu_rvalid) begin
                    rv_pulses++;
                    if (rd_q.size() == 0) begin
                        total_cnt++;
                        $display("FAIL unexpected_rvalid: got rdata 0x%08h, required no result", lsu_rdata);
                    end else chk("load_rdata", lsu_rdata, rd_q.pop_front());
                end
                if (lsu_err) err_pulses++;
            end
        end
    end

    task automatic op(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd,
                      input int gw, input int rw, input logic [31:0] rword,
                      input logic [3:0] e_be, input logic [31:0] e_addr, input logic [31:0] e_wd,
                      input logic [31:0] e_rd, input logic e_err, input int e_stall, input string name);
        bus_t b;
        int   stalls = 0;
        bit   finished = 0;
        gnt_wait = gw; rv_wait = rw; rd_word = rword;
        if (!e_err) begin
            b.we = we; b.be = e_be; b.addr = e_addr; b.wdata = e_wd;
            bus_q.push_back(b);
            if (!we) rd_q.push_back(e_rd);
        end
        ex_valid = 1'b1; ex_we = we; ex_func3 = f3; ex_addr = addr; ex_wdata = wd;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (!lsu_stall) begin finished = 1; break; end
            stalls++;
            @(posedge clk); #1;
        end
        if (!finished) begin
            total_cnt++;
            $display("FAIL %s_timeout: got stall still high after 200 cycles, required release", name);
        end else chk({name, "_stall"}, 32'(stalls), 32'(e_stall));
        @(posedge clk); #1;
        ex_valid = 1'b0;
    endtask

    initial begin
        int p;
        ex_valid = 1'b0; ex_we = 1'b0; ex_func3 = 3'd0; ex_addr = 32'd0; ex_wdata = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_rdata", lsu_rdata, 32'd0);
        chk("rst_be", 32'(dmem_be), 32'd0);
        chk("rst_addr", 32'(dmem_addr), 32'd0);
        chk("rst_wdata", dmem_wdata, 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(lsu_stall), 32'd0);
        chk("rst_rvalid", 32'(lsu_rvalid), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        op(1'b1, 3'd0, 32'h0000_0103, 32'hAABBCCDD, 0, 0, 32'd0, 4'b1000, 32'h40, 32'hDDDDDDDD, 32'd0, 1'b0, 1, "sb");
        op(1'b0, 3'd0, 32'h0000_0002, 32'd0, 2, 1, 32'h0080_0000, 4'b0100, 32'h0, 32'd0, 32'hFFFF_FF80, 1'b0, 5, "lb");
        op(1'b0, 3'd4, 32'h0000_0002, 32'd0, 2, 1, 32'h0080_0000, 4'b0100, 32'h0, 32'd0, 32'h0000_0080, 1'b0, 5, "lbu");
        op(1'b0, 3'd5, 32'h0000_0006, 32'd0, 0, 0, 32'hBEEF_1234, 4'b1100, 32'h1, 32'd0, 32'h0000_BEEF, 1'b0, 2, "lhu");
        op(1'b0, 3'd1, 32'h0000_0006, 32'd0, 0, 0, 32'hBEEF_1234, 4'b1100, 32'h1, 32'd0, 32'hFFFF_BEEF, 1'b0, 2, "lh");
        op(1'b1, 3'd1, 32'h0000_0002, 32'h12345678, 1, 0, 32'd0, 4'b1100, 32'h0, 32'h56785678, 32'd0, 1'b0, 2, "sh");
        op(1'b1, 3'd2, 32'h0000_0010, 32'hCAFEF00D, 0, 0, 32'd0, 4'hF, 32'h4, 32'hCAFEF00D, 32'd0, 1'b0, 1, "sw");
        op(1'b0, 3'd2, 32'h0000_0008, 32'd0, 0, 2, 32'h89ABCDEF, 4'hF, 32'h2, 32'd0, 32'h89ABCDEF, 1'b0, 4, "lw");
        op(1'b0, 3'd7, 32'h0000_000C, 32'd0, 0, 0, 32'h01234567, 4'hF, 32'h3, 32'd0, 32'h01234567, 1'b0, 2, "lw_f3_7");
        op(1'b0, 3'd0, 32'h0000_0007, 32'd0, 0, 0, 32'h7F00_0000, 4'b1000, 32'h1, 32'd0, 32'h0000_007F, 1'b0, 2, "lb_off3");
`ifdef RV_LSU_ALIGN_CHECK_EN
        op(1'b0, 3'd2, 32'h0000_0005, 32'd0, 0, 0, 32'h11111111, 4'h0, 32'h0, 32'd0, 32'd0, 1'b1, 0, "lw_misalign");
        op(1'b1, 3'd1, 32'h0000_0003, 32'h0000ABCD, 0, 0, 32'd0, 4'h0, 32'h0, 32'd0, 32'd0, 1'b1, 0, "sh_misalign");
`else
        op(1'b0, 3'd2, 32'h0000_0005, 32'd0, 0, 0, 32'h11111111, 4'hF, 32'h1, 32'd0, 32'h11111111, 1'b0, 2, "lw_misalign");
        op(1'b1, 3'd1, 32'h0000_0003, 32'h0000ABCD, 0, 0, 32'd0, 4'b1100, 32'h0, 32'hABCDABCD, 32'd0, 1'b0, 1, "sh_misalign");
`endif
        repeat (2) @(posedge clk); #1;

        // Back-to-back store then load, with rvalid glitching during every request cycle
        spur = 1'b1;
        op(1'b1, 3'd2, 32'h0000_0020, 32'h0BADF00D, 0, 0, 32'd0, 4'hF, 32'h8, 32'h0BADF00D, 32'd0, 1'b0, 1, "b2b_sw");
        op(1'b0, 3'd2, 32'h0000_0024, 32'd0, 0, 0, 32'h600DCAFE, 4'hF, 32'h9, 32'd0, 32'h600DCAFE, 1'b0, 2, "b2b_lw");
        spur = 1'b0;
        chk("b2b_req_gap", 32'(req_rise - last_store_gnt), 32'd2);
        repeat (2) @(posedge clk); #1;

        // Reset while waiting for a grant: request must drop without a clock edge
        gnt_wait = 100;
        ex_valid = 1'b1; ex_we = 1'b0; ex_func3 = 3'd2; ex_addr = 32'h30; ex_wdata = 32'd0;
        @(negedge clk); @(posedge clk); #1;
        chk("req_before_rst", 32'(dmem_req), 32'd1);
        #2 rst_n = 1'b0; ex_valid = 1'b0;
        #1 chk("req_async_drop", 32'(dmem_req), 32'd0);
        chk("stall_in_rst", 32'(lsu_stall), 32'd0);
        @(negedge clk);
        chk("rst2_rdata", lsu_rdata, 32'd0);
        chk("rst2_be", 32'(dmem_be), 32'd0);
        chk("rst2_addr", 32'(dmem_addr), 32'd0);
        @(posedge clk); @(negedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Reset while waiting for read data; the late rvalid must produce nothing
        gnt_wait = 0; rv_wait = 3; rd_word = 32'h0000_00AA;
        begin
            bus_t b;
            b.we = 1'b0; b.be = 4'b0010; b.addr = 32'h0; b.wdata = 32'd0;
            bus_q.push_back(b);
        end
        ex_valid = 1'b1; ex_we = 1'b0; ex_func3 = 3'd0; ex_addr = 32'h1; ex_wdata = 32'd0;
        @(negedge clk); @(posedge clk); #1;
        @(negedge clk); @(posedge clk); #1;
        #2 rst_n = 1'b0; ex_valid = 1'b0;
        #1 chk("resp_rst_req", 32'(dmem_req), 32'd0);
        chk("resp_rst_stall", 32'(lsu_stall), 32'd0);
        @(posedge clk); @(negedge clk); #1 rst_n = 1'b1;
        p = rv_pulses;
        repeat (8) @(posedge clk);
        #1 chk("late_rvalid_ignored", 32'(rv_pulses), 32'(p));
        chk("late_rdata", lsu_rdata, 32'd0);

        chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
        chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
        chk("err_pulses", 32'(err_pulses), 32'(EXP_ERRS));
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at 200000, required completion");
        $fatal(1, "watchdog");
    end
endmodule
